// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state encoding, quarter-bit phases
// and the default clock divider.
package i2c_pkg;

  localparam int CLK_DIV_DEFAULT = 50;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    MNACK,
    STOP,
    DONE
  } state_t;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_tick.sv
// Quarter-bit tick generator: pulses once every CLK_DIV enabled clk cycles.
module i2c_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [8:0] count;

  assign tick = en && (count == 9'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 9'd1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+rw, one data byte written or read,
// STOP. Each bit is split into four quarter phases driven by i2c_tick.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  wire        SDA
);

  state_t   state, state_n;
  quarter_t quarter, quarter_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] wdata_r, wdata_n;
  logic [7:0] rdata_n;
  logic       rw_r, rw_n;
  logic       scl_r, scl_n;
  logic       sda_low, sda_low_n;
  logic       ack_err_n;
  logic       tick;
  logic       accept;
  logic       sda_in;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign accept  = (state == IDLE) && start;
  assign SCL     = scl_r;
  assign SDA     = sda_low ? 1'b0 : 1'bz;
  assign sda_in  = SDA;

  i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      quarter <= Q0;
      bit_cnt <= '0;
      shift   <= '0;
      wdata_r <= '0;
      rw_r    <= 1'b0;
      scl_r   <= 1'b1;
      sda_low <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_n;
      quarter <= quarter_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      wdata_r <= wdata_n;
      rw_r    <= rw_n;
      scl_r   <= scl_n;
      sda_low <= sda_low_n;
      ack_err <= ack_err_n;
      rdata   <= rdata_n;
    end
  end

  // Actions happen on a tick for the quarter being left: Q0 drive SDA,
  // Q1 raise SCL, Q2 sample SDA, Q3 lower SCL and pick the next bit/state.
  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    wdata_n   = wdata_r;
    rw_n      = rw_r;
    scl_n     = scl_r;
    sda_low_n = sda_low;
    ack_err_n = ack_err;
    rdata_n   = rdata;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = START;
          quarter_n = Q0;
          shift_n   = {addr, rw};
          wdata_n   = wdata;
          rw_n      = rw;
          ack_err_n = 1'b0;
          scl_n     = 1'b1;
          sda_low_n = 1'b0;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        if (tick) begin
          quarter_n = quarter + 2'd1;
          case (quarter)
            Q0: begin
              case (state)
                START, STOP: sda_low_n = 1'b1;
                ADDR, WDATA: sda_low_n = ~shift[7];
                default:     sda_low_n = 1'b0;
              endcase
            end
            Q1: scl_n = (state != START);
            Q2: begin
              case (state)
                STOP:           sda_low_n = 1'b0;
                ADDR_ACK, WACK: if (sda_in) ack_err_n = 1'b1;
                RDATA:          shift_n = {shift[6:0], sda_in};
                default: ;
              endcase
            end
            Q3: begin
              // SCL stays high after the STOP rise; everywhere else it falls.
              if (state != STOP) scl_n = 1'b0;
              case (state)
                START: begin
                  state_n   = ADDR;
                  bit_cnt_n = 3'd7;
                end
                ADDR, WDATA: begin
                  if (bit_cnt == 3'd0) begin
                    state_n = (state == ADDR) ? ADDR_ACK : WACK;
                  end else begin
                    bit_cnt_n = bit_cnt - 3'd1;
                    shift_n   = {shift[6:0], 1'b0};
                  end
                end
                ADDR_ACK: begin
                  bit_cnt_n = 3'd7;
                  if (ack_err)   state_n = STOP;
                  else if (rw_r) state_n = RDATA;
                  else begin
                    state_n = WDATA;
                    shift_n = wdata_r;
                  end
                end
                RDATA: begin
                  if (bit_cnt == 3'd0) begin
                    state_n = MNACK;
                    rdata_n = shift;
                  end else begin
                    bit_cnt_n = bit_cnt - 3'd1;
                  end
                end
                WACK, MNACK: state_n = STOP;
                STOP:        state_n = DONE;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50, giving the clk cycles per quarter SCL bit period; legal range 2..511.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, accepted only when busy=0.
REQ-005 The block SHALL have port addr, input, 7 bits: target slave address, sampled on accept.
REQ-006 The block SHALL have port rw, input, 1 bit: 0=write, 1=read, sampled on accept.
REQ-007 The block SHALL have port wdata, input, 8 bits: write byte, sampled on accept.
REQ-008 The block SHALL have port rdata, output, 8 bits: read byte, valid when done=1 and the transfer was a read.
REQ-009 The block SHALL have port busy, output, 1 bit: high from accept until the done pulse.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a transfer.
REQ-011 The block SHALL have port ack_err, output, 1 bit: NACK seen; valid with done and held until the next accept.
REQ-012 The block SHALL have port SCL, output, 1 bit: push-pull bus clock, idle high (the downstream slave's SCL is input-only).
REQ-013 The block SHALL have port SDA, inout, 1 bit: open-drain; driven 0 or high-Z only, never driven 1.

Function
REQ-014 A tick SHALL pulse every CLK_DIV clk cycles while busy=1; the divider SHALL be cleared on accept. Each bit SHALL take 4 ticks: Q0 SCL low / SDA update, Q1 SCL rises, Q2 SDA sampled, Q3 SCL falls.
REQ-015 The FSM SHALL have the states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MNACK, STOP, DONE.
REQ-016 The transition IDLE->START SHALL occur on start=1 with busy=0; a start while busy=1 SHALL be ignored.
REQ-017 In START, SDA SHALL fall while SCL=1 and SCL SHALL fall 1 tick later.
REQ-018 ADDR SHALL send {addr,rw} MSB first over 8 bits, then go to ADDR_ACK.
REQ-019 In ADDR_ACK, SDA SHALL be released and sampled at Q2: 0 -> WDATA if rw=0, RDATA if rw=1; 1 -> set ack_err, go to STOP.
REQ-020 WDATA SHALL send wdata MSB first; WACK SHALL sample the ACK, with 1 setting ack_err; then go to STOP.
REQ-021 RDATA SHALL shift 8 bits sampled at Q2, MSB first; MNACK SHALL release SDA (master NACK) for 1 bit; then go to STOP.
REQ-022 In STOP, SDA SHALL be driven 0 with SCL low, then SCL SHALL rise, then SDA SHALL be released 1 tick later; then go to DONE.
REQ-023 DONE SHALL last 1 clk: done=1, busy=0 on the next cycle, then IDLE; back-to-back start is accepted in the cycle after done.
REQ-024 The bit counter SHALL be 3 bits and count 7 down to 0; 0 ends the byte, with no wrap into the next state.
REQ-025 rdata SHALL hold its last value until the next read completes; on NACK-terminated reads it SHALL remain unchanged.

Reset
REQ-026 On rst=1 at a clk edge: state=IDLE, SCL=1, SDA=high-Z, busy=0, done=0, ack_err=0, rdata=0x00, divider=0.
REQ-027 Reset mid-transfer SHALL abort immediately with no STOP generated; the bus is released on the next cycle.

Structure
REQ-028 The state encoding, the quarter-phase constants Q0..Q3 and the default CLK_DIV SHALL live in the shared package i2c_pkg.
REQ-029 The tick divider SHALL be the sub-module i2c_tick (clk, rst, en, clr, tick); all other logic SHALL stay in i2c_master.
REQ-030 The SDA drive SHALL be a single assign of 0 or high-Z from a registered drive-low flag.

Verification
REQ-031 Write addr=0x12, wdata=0xA5, slave ACKs -> bus shows START, byte 0x24, ACK, byte 0xA5, ACK, STOP; done=1, ack_err=0.
REQ-032 Write to addr=0x55 with no slave (SDA pulled high) -> ack_err=1; STOP follows ADDR_ACK; no data byte; done pulses.
REQ-033 Read addr=0x12, slave returns 0x3C -> byte 0x25, ACK, rdata=0x3C, master NACK (SDA high on the 9th bit), STOP.
REQ-034 CLK_DIV=50 -> SCL period = 200 clk; SDA changes only while SCL=0 except at START/STOP; start while busy is ignored.
REQ-035 Assert rst during the RDATA bit 3 -> next cycle SCL=1, SDA=Z, busy=0, no done pulse; a following write completes normally.
